// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_controller_pkg;

  typedef enum logic [1:0] {RUN, TRAP, MRET, WFI} trap_state_e;

  typedef enum logic [1:0] {
    CSR_MSTATUS = 2'd0,
    CSR_MEPC    = 2'd1,
    CSR_MCAUSE  = 2'd2,
    CSR_RSVD    = 2'd3
  } csr_sel_e;

  localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  function automatic logic [31:0] irq_cause(input logic [3:0] code);
    return {1'b1, 27'd0, code};
  endfunction

endpackage

// File: rtl/trap_controller_irq_prio.sv
// Fixed-priority interrupt selector: MEI over MSI over MTI.
module trap_irq_prio
  import trap_controller_pkg::*;
(
  input  logic [2:0] pend_i,   // {mei, mti, msi}, already masked by enables
  output logic       valid_o,
  output logic [3:0] code_o
);

  always_comb begin
    valid_o = |pend_i;
    code_o  = IRQ_MTI;
    if (pend_i[2])      code_o = IRQ_MEI;
    else if (pend_i[0]) code_o = IRQ_MSI;
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: owns mepc/mcause/MIE/MPIE, stalls and flushes the
// pipeline, and redirects the PC for traps, MRET and WFI wake-up.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            exc_request,
  input  logic [31:0]     exc_cause,
  input  logic            is_mret,
  input  logic            is_wfi,
  input  logic [2:0]      irq_pending,
  input  logic [2:0]      irq_enable,
  input  logic [XLEN-1:0] mtvec,
  input  logic            csr_we,
  input  logic [1:0]      csr_sel,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mepc,
  output logic [31:0]     mcause,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic            sleeping
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cause_q, cause_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [31:0]     mcause_q, mcause_d;
  logic            mie_q, mie_d, mpie_q, mpie_d;

  logic [2:0]      irq_act;
  logic            irq_valid;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] vec_base, trap_target;

  assign irq_act = irq_pending & irq_enable;

  trap_irq_prio u_prio (
    .pend_i  (irq_act),
    .valid_o (irq_valid),
    .code_o  (irq_code)
  );

  // Vectored mode only applies to interrupts; exceptions always land on the base.
  assign vec_base    = {mtvec[XLEN-1:2], 2'b00};
  assign trap_target = (VECTORED_EN && mtvec[1:0] == 2'b01 && cause_q[31])
                     ? vec_base + (XLEN'(cause_q[30:0]) << 2) : vec_base;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mie_d          = mie_q;
    mpie_d         = mpie_q;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    sleeping       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (instr_valid) begin
          if (mie_q && irq_valid) begin
            flush   = 1'b1;
            stall   = 1'b1;
            pc_d    = instr_pc;
            cause_d = irq_cause(irq_code);
            state_d = TRAP;
          end else if (exc_request) begin
            flush   = 1'b1;
            stall   = 1'b1;
            pc_d    = instr_pc;
            cause_d = exc_cause;
            state_d = TRAP;
          end else if (is_mret) begin
            stall   = 1'b1;
            state_d = MRET;
          end else if (is_wfi) begin
            stall   = 1'b1;
            pc_d    = instr_pc;
            state_d = WFI;
          end
        end
        // A flushed instruction must not commit its CSR write.
        if (csr_we && !flush) begin
          unique case (csr_sel_e'(csr_sel))
            CSR_MSTATUS: begin
              mie_d  = csr_wdata[3];
              mpie_d = csr_wdata[7];
            end
            CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE: mcause_d = csr_wdata[31:0];
            default: ;
          endcase
        end
      end
      TRAP: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
        mepc_d         = pc_q;
        mcause_d       = cause_q;
        mpie_d         = mie_q;
        mie_d          = 1'b0;
        state_d        = RUN;
      end
      MRET: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc_q;
        mie_d          = mpie_q;
        mpie_d         = 1'b1;
        state_d        = RUN;
      end
      WFI: begin
        sleeping = 1'b1;
        stall    = 1'b1;
        // Wake ignores MIE; MIE only decides between trapping and resuming.
        if (irq_valid) begin
          if (mie_q) begin
            pc_d    = pc_q + XLEN'(4);
            cause_d = irq_cause(irq_code);
            state_d = TRAP;
          end else begin
            redirect_valid = 1'b1;
            redirect_pc    = pc_q + XLEN'(4);
            state_d        = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= '0;
      cause_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
    end
  end

  assign mepc         = mepc_q;
  assign mcause       = mcause_q;
  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: vector table for single-trap flows plus
// hand-written WFI, CSR-write and reset sequences.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        exc_request;
  logic [31:0] exc_cause;
  logic        is_mret, is_wfi;
  logic [2:0]  irq_pending, irq_enable;
  logic [31:0] mtvec;
  logic        csr_we;
  logic [1:0]  csr_sel;
  logic [31:0] csr_wdata;
  logic        stall, flush, redirect_valid, sleeping;
  logic [31:0] redirect_pc, mepc, mcause;
  logic        mstatus_mie, mstatus_mpie;

  int n_chk = 0;
  int n_fail = 0;

  trap_controller #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .exc_request(exc_request), .exc_cause(exc_cause), .is_mret(is_mret), .is_wfi(is_wfi),
    .irq_pending(irq_pending), .irq_enable(irq_enable), .mtvec(mtvec), .csr_we(csr_we),
    .csr_sel(csr_sel), .csr_wdata(csr_wdata), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mepc(mepc), .mcause(mcause),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mstatus;
    logic [31:0] mepc_init;
    logic [31:0] pc;
    logic        exc;
    logic [31:0] cause;
    logic        mret;
    logic        wfi;
    logic [2:0]  pend;
    logic [2:0]  en;
    logic [31:0] tvec;
    logic        e_flush;
    logic        e_stall;
    logic [31:0] e_rpc;
    logic [31:0] e_mepc;
    logic [31:0] e_mcause;
    logic        e_mie;
    logic        e_mpie;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0; instr_pc = '0; exc_request = 1'b0; exc_cause = '0;
    is_mret = 1'b0; is_wfi = 1'b0; irq_pending = '0; irq_enable = '0;
    mtvec = 32'h200; csr_we = 1'b0; csr_sel = 2'd0; csr_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic csr_wr(input logic [1:0] sel, input logic [31:0] d);
    csr_we = 1'b1; csr_sel = sel; csr_wdata = d;
    cyc();
    csr_we = 1'b0;
  endtask

  initial begin
    //          mst    mepc_i        pc            exc   cause        mret  wfi   pend    en      mtvec          fl    st    rpc           mepc          mcause        mie   mpie
    vecs[0] = '{8'h08, 32'h0,        32'h100,      1'b1, 32'd11,      1'b0, 1'b0, 3'b000, 3'b000, 32'h200,       1'b1, 1'b1, 32'h200,      32'h100,      32'd11,       1'b0, 1'b1};
    vecs[1] = '{8'h08, 32'h0,        32'h40,       1'b0, 32'd0,       1'b0, 1'b0, 3'b010, 3'b010, 32'h201,       1'b1, 1'b1, 32'h21C,      32'h40,       32'h80000007, 1'b0, 1'b1};
    vecs[2] = '{8'h08, 32'h0,        32'h300,      1'b1, 32'd11,      1'b0, 1'b0, 3'b111, 3'b111, 32'h200,       1'b1, 1'b1, 32'h200,      32'h300,      32'h8000000B, 1'b0, 1'b1};
    vecs[3] = '{8'h08, 32'h0,        32'h10,       1'b0, 32'd0,       1'b0, 1'b0, 3'b011, 3'b011, 32'h1001,      1'b1, 1'b1, 32'h100C,     32'h10,       32'h80000003, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 32'h0,        32'h20,       1'b1, 32'd2,       1'b0, 1'b0, 3'b111, 3'b111, 32'h201,       1'b1, 1'b1, 32'h200,      32'h20,       32'd2,        1'b0, 1'b0};
    vecs[5] = '{8'h80, 32'h104,      32'h500,      1'b0, 32'd0,       1'b1, 1'b0, 3'b000, 3'b000, 32'h200,       1'b0, 1'b1, 32'h104,      32'h104,      32'd0,        1'b1, 1'b1};
    vecs[6] = '{8'h80, 32'h208,      32'h600,      1'b0, 32'd0,       1'b1, 1'b0, 3'b001, 3'b001, 32'h200,       1'b0, 1'b1, 32'h208,      32'h208,      32'd0,        1'b1, 1'b1};
    vecs[7] = '{8'h08, 32'h0,        32'h70,       1'b1, 32'd3,       1'b0, 1'b0, 3'b111, 3'b000, 32'h201,       1'b1, 1'b1, 32'h200,      32'h70,       32'd3,        1'b0, 1'b1};
    vecs[8] = '{8'h08, 32'h0,        32'hFFFFFFFC, 1'b1, 32'd11,      1'b0, 1'b0, 3'b100, 3'b100, 32'hFFFFFFFD,  1'b1, 1'b1, 32'h28,       32'hFFFFFFFC, 32'h8000000B, 1'b0, 1'b1};
    vecs[9] = '{8'h80, 32'h104,      32'h30,       1'b1, 32'd2,       1'b1, 1'b0, 3'b000, 3'b000, 32'h200,       1'b1, 1'b1, 32'h200,      32'h30,       32'd2,        1'b0, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_mepc", mepc, 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_mie", 32'(mstatus_mie), 32'd0);
    chk("rst_mpie", 32'(mstatus_mpie), 32'd0);
    chk("rst_sleeping", 32'(sleeping), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      csr_wr(2'd0, {24'd0, vecs[i].mstatus});
      csr_wr(2'd1, vecs[i].mepc_init);
      mtvec = vecs[i].tvec; irq_pending = vecs[i].pend; irq_enable = vecs[i].en;
      instr_valid = 1'b1; instr_pc = vecs[i].pc; exc_request = vecs[i].exc;
      exc_cause = vecs[i].cause; is_mret = vecs[i].mret; is_wfi = vecs[i].wfi;
      @(negedge clk);
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      cyc();
      instr_valid = 1'b0; exc_request = 1'b0; is_mret = 1'b0; is_wfi = 1'b0;
      irq_pending = '0;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 32'(redirect_valid), 32'd1);
      chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d_flush2", i), 32'(flush), 32'd0);
      cyc();
      @(negedge clk);
      chk($sformatf("v%0d_mepc", i), mepc, vecs[i].e_mepc);
      chk($sformatf("v%0d_mcause", i), mcause, vecs[i].e_mcause);
      chk($sformatf("v%0d_mie", i), 32'(mstatus_mie), 32'(vecs[i].e_mie));
      chk($sformatf("v%0d_mpie", i), 32'(mstatus_mpie), 32'(vecs[i].e_mpie));
      chk($sformatf("v%0d_idle", i), 32'({stall, redirect_valid}), 32'd0);
      cyc();
    end

    // WFI with MIE=0: sleep, then resume at pc+4 without trapping.
    do_reset();
    irq_enable = 3'b001;
    instr_valid = 1'b1; instr_pc = 32'h80; is_wfi = 1'b1;
    @(negedge clk);
    chk("wfi0_stall", 32'(stall), 32'd1);
    chk("wfi0_flush", 32'(flush), 32'd0);
    cyc();
    instr_valid = 1'b0; is_wfi = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("wfi0_sleep%0d", k), 32'({sleeping, stall, redirect_valid}), 32'b110);
      cyc();
    end
    irq_pending = 3'b001;
    @(negedge clk);
    chk("wfi0_wake_rv", 32'(redirect_valid), 32'd1);
    chk("wfi0_wake_pc", redirect_pc, 32'h84);
    cyc();
    irq_pending = '0;
    @(negedge clk);
    chk("wfi0_awake", 32'({sleeping, stall, redirect_valid}), 32'd0);
    chk("wfi0_mepc", mepc, 32'd0);
    chk("wfi0_mcause", mcause, 32'd0);

    // WFI with MIE=1: wake traps with mepc = wfi pc + 4.
    do_reset();
    csr_wr(2'd0, 32'h08);
    irq_enable = 3'b010;
    instr_valid = 1'b1; instr_pc = 32'h90; is_wfi = 1'b1;
    cyc();
    instr_valid = 1'b0; is_wfi = 1'b0;
    cyc();
    irq_pending = 3'b010;
    @(negedge clk);
    chk("wfi1_sleep", 32'({sleeping, redirect_valid}), 32'b10);
    cyc();
    irq_pending = '0;
    @(negedge clk);
    chk("wfi1_rv", 32'(redirect_valid), 32'd1);
    chk("wfi1_rpc", redirect_pc, 32'h200);
    cyc();
    @(negedge clk);
    chk("wfi1_mepc", mepc, 32'h94);
    chk("wfi1_mcause", mcause, 32'h80000007);
    chk("wfi1_mstatus", 32'({mstatus_mie, mstatus_mpie}), 32'b01);

    // Interrupt with no valid instruction boundary must wait.
    do_reset();
    csr_wr(2'd0, 32'h08);
    irq_pending = 3'b100; irq_enable = 3'b100;
    @(negedge clk);
    chk("noinst_flush", 32'(flush), 32'd0);
    cyc();
    @(negedge clk);
    chk("noinst_rv", 32'(redirect_valid), 32'd0);
    irq_pending = '0; irq_enable = '0;

    // CSR writes: mepc alignment, mcause, reserved select, mstatus.
    do_reset();
    csr_wr(2'd1, 32'h123);
    @(negedge clk);
    chk("csr_mepc", mepc, 32'h120);
    csr_wr(2'd2, 32'h8000_0055);
    @(negedge clk);
    chk("csr_mcause", mcause, 32'h8000_0055);
    csr_wr(2'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("csr_rsvd_mepc", mepc, 32'h120);
    chk("csr_rsvd_mst", 32'({mstatus_mie, mstatus_mpie}), 32'd0);
    csr_wr(2'd0, 32'h88);
    @(negedge clk);
    chk("csr_mstatus", 32'({mstatus_mie, mstatus_mpie}), 32'b11);

    // CSR write in the same cycle as an exception is dropped.
    do_reset();
    instr_valid = 1'b1; instr_pc = 32'h60; exc_request = 1'b1; exc_cause = 32'd2;
    csr_we = 1'b1; csr_sel = 2'd1; csr_wdata = 32'h500;
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("csrx_mepc_hold", mepc, 32'd0);
    cyc();
    @(negedge clk);
    chk("csrx_mepc_trap", mepc, 32'h60);

    // Asynchronous reset while in TRAP.
    do_reset();
    csr_wr(2'd0, 32'h08);
    csr_wr(2'd1, 32'h444);
    csr_wr(2'd2, 32'h7);
    instr_valid = 1'b1; instr_pc = 32'h70; exc_request = 1'b1; exc_cause = 32'd11;
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("rstx_in_trap", 32'(redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstx_rv", 32'(redirect_valid), 32'd0);
    chk("rstx_stall", 32'(stall), 32'd0);
    chk("rstx_mepc", mepc, 32'd0);
    chk("rstx_mcause", mcause, 32'd0);
    chk("rstx_mst", 32'({mstatus_mie, mstatus_mpie}), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("rstx_after", 32'({redirect_valid, mepc[0], mstatus_mpie}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
